// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds size codes, state/owner encodings, bus widths and byte-count helpers.
package mem_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic True      = 1'b1;
  localparam logic False     = 1'b0;

  localparam int unsigned RamAddrBus = 32;
  localparam int unsigned RamDataBus = 8;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  typedef enum logic [1:0] {
    McIdle  = 2'b00,
    McRead  = 2'b01,
    McWrite = 2'b10,
    McDone  = 2'b11
  } mc_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  // Size code 11 falls through to a full word.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    logic [2:0] count;
    case (size)
      MemByte: count = 3'd1;
      MemHalf: count = 3'd2;
      default: count = 3'd4;
    endcase
    return count;
  endfunction

  function automatic logic [31:0] keep_low_bytes(input logic [31:0] data, input logic [2:0] n);
    logic [31:0] mask;
    case (n)
      3'd1:    mask = 32'h0000_00ff;
      3'd2:    mask = 32'h0000_ffff;
      default: mask = 32'hffff_ffff;
    endcase
    return data & mask;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter between instruction fetch and the MEM stage on one 8-bit RAM port.
// Raises the stall requests and drops speculative fetches on a taken branch.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RamAddrBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_stall_req_o,
  input  logic                  flush_i,
  input  logic [RamDataBus-1:0] ram_din_i,
  output logic [RamDataBus-1:0] ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o
);

  mc_state_e             state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  if_done_raw;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= McIdle;
      owner_q     <= OwnIf;
      base_q      <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    n_d         = n_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr_o    = False;
    ram_addr_o  = '0;
    ram_dout_o  = '0;
    if_done_raw = False;
    mem_done_o  = False;

    unique case (state_q)
      McIdle: begin
        if (mem_req_i) begin
          owner_d = OwnMem;
          base_d  = mem_addr_i;
          n_d     = size_to_count(mem_size_i);
          idx_d   = '0;
          state_d = mem_we_i ? McWrite : McRead;
        end else if (if_req_i && !flush_i) begin
          owner_d = OwnIf;
          base_d  = if_addr_i;
          n_d     = 3'd4;
          idx_d   = '0;
          state_d = McRead;
        end
      end

      McRead: begin
        // The final cycle re-presents the last address while its byte returns.
        if (idx_q < n_q) begin
          ram_addr_o = base_q + ADDR_WIDTH'(idx_q);
        end else begin
          ram_addr_o = base_q + ADDR_WIDTH'(n_q - 3'd1);
        end
        for (int k = 0; k < 4; k++) begin
          if (idx_q == 3'(k + 1)) begin
            buf_d[k*8 +: 8] = ram_din_i;
          end
        end
        if (owner_q == OwnIf && flush_i) begin
          state_d = McIdle;
          idx_d   = '0;
        end else if (idx_q == n_q) begin
          state_d = McDone;
          if (owner_q == OwnIf) begin
            if_data_d = keep_low_bytes(buf_d, n_q);
          end else begin
            mem_rdata_d = keep_low_bytes(buf_d, n_q);
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      McWrite: begin
        ram_wr_o   = True;
        ram_addr_o = base_q + ADDR_WIDTH'(idx_q);
        for (int k = 0; k < 4; k++) begin
          if (idx_q == 3'(k)) begin
            ram_dout_o = mem_wdata_i[k*8 +: 8];
          end
        end
        if (idx_q == n_q - 3'd1) begin
          state_d = McDone;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      McDone: begin
        if (owner_q == OwnIf) begin
          if_done_raw = True;
        end else begin
          mem_done_o = True;
        end
        state_d = McIdle;
      end

      default: state_d = McIdle;
    endcase
  end

  // A branch resolving in the DONE cycle makes the fetched word stale.
  assign if_done_o       = if_done_raw && !flush_i;
  assign if_stall_req_o  = if_req_i && !if_done_o;
  assign mem_stall_req_o = mem_req_i && !mem_done_o;
  assign if_data_o       = if_data_q;
  assign mem_rdata_o     = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, store/fetch priority, half load, flush and reset cases.
// A small RAM model answers reads one cycle late and logs writes.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        if_stall_req_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_stall_req_o;
  logic        flush_i;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;

  logic [7:0]  wmem [0:4095];
  int          checks = 0;
  int          errors = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .if_data_o       (if_data_o),
    .if_done_o       (if_done_o),
    .if_stall_req_o  (if_stall_req_o),
    .mem_req_i       (mem_req_i),
    .mem_we_i        (mem_we_i),
    .mem_size_i      (mem_size_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_rdata_o     (mem_rdata_o),
    .mem_done_o      (mem_done_o),
    .mem_stall_req_o (mem_stall_req_o),
    .flush_i         (flush_i),
    .ram_din_i       (ram_din_i),
    .ram_dout_o      (ram_dout_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wr_o        (ram_wr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h010: return 8'h13;
      32'h011: return 8'h05;
      32'h012: return 8'h10;
      32'h013: return 8'h00;
      32'h020: return 8'h11;
      32'h021: return 8'h22;
      32'h022: return 8'h33;
      32'h023: return 8'h44;
      32'h030: return 8'h01;
      32'h031: return 8'h02;
      32'h032: return 8'h03;
      32'h033: return 8'h04;
      32'h040: return 8'hAA;
      32'h041: return 8'hBB;
      32'h042: return 8'hCC;
      32'h043: return 8'hDD;
      32'h201: return 8'h80;
      32'h202: return 8'hFF;
      32'h203: return 8'h77;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    ram_din_i <= rom(ram_addr_o);
    if (ram_wr_o) wmem[ram_addr_o[11:0]] <= ram_dout_o;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (if_data_o !== 32'h0) begin errors++; $display("FAIL reset_if_data got %h want 0", if_data_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata_o); end
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", if_done_o); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL reset_mem_done got %b want 0", mem_done_o); end
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got %b want 0", ram_wr_o); end
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr_o); end
    checks++; if (ram_dout_o !== 8'h0) begin errors++; $display("FAIL reset_ram_dout got %h want 0", ram_dout_o); end
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_if_stall got %b want 0", if_stall_req_o); end
  endtask

  task automatic test_if_fetch();
    logic [31:0] exp_addr;
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    #1;
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("FAIL fetch_stall got %b want 1", if_stall_req_o); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      exp_addr = (k < 4) ? 32'h10 + 32'(k - 1) : 32'h13;
      checks++; if (ram_addr_o !== exp_addr) begin errors++; $display("FAIL fetch_addr k=%0d got %h want %h", k, ram_addr_o, exp_addr); end
      checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL fetch_early_done k=%0d got %b want 0", k, if_done_o); end
    end
    cyc();
    checks++; if (if_done_o !== 1'b1) begin errors++; $display("FAIL fetch_done got %b want 1", if_done_o); end
    checks++; if (if_data_o !== 32'h0010_0513) begin errors++; $display("FAIL fetch_data got %h want 00100513", if_data_o); end
    checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("FAIL fetch_stall_drop got %b want 0", if_stall_req_o); end
    if_req_i = 1'b0;
    cyc();
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse got %b want 0", if_done_o); end
    checks++; if (if_data_o !== 32'h0010_0513) begin errors++; $display("FAIL fetch_data_hold got %h want 00100513", if_data_o); end
  endtask

  task automatic test_priority();
    logic [7:0] exp_b;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_size_i  = 2'b10;
    mem_addr_i  = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h20;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp_b = 8'(mem_wdata_i >> (8 * (k - 1)));
      checks++; if (ram_wr_o !== 1'b1) begin errors++; $display("FAIL store_wr k=%0d got %b want 1", k, ram_wr_o); end
      checks++; if (ram_addr_o !== 32'h100 + 32'(k - 1)) begin errors++; $display("FAIL store_addr k=%0d got %h want %h", k, ram_addr_o, 32'h100 + 32'(k - 1)); end
      checks++; if (ram_dout_o !== exp_b) begin errors++; $display("FAIL store_dout k=%0d got %h want %h", k, ram_dout_o, exp_b); end
    end
    cyc();
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL store_done got %b want 1", mem_done_o); end
    checks++; if (mem_stall_req_o !== 1'b0) begin errors++; $display("FAIL store_stall got %b want 0", mem_stall_req_o); end
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL store_wr_off got %b want 0", ram_wr_o); end
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("FAIL pending_if_stall got %b want 1", if_stall_req_o); end
    mem_req_i = 1'b0;
    cyc();
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL idle_addr got %h want 0", ram_addr_o); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL store_done_pulse got %b want 0", mem_done_o); end
    cyc();
    checks++; if (ram_addr_o !== 32'h20) begin errors++; $display("FAIL pending_if_addr got %h want 00000020", ram_addr_o); end
    repeat (4) cyc();
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL pending_if_early got %b want 0", if_done_o); end
    cyc();
    checks++; if (if_done_o !== 1'b1) begin errors++; $display("FAIL pending_if_done got %b want 1", if_done_o); end
    checks++; if (if_data_o !== 32'h4433_2211) begin errors++; $display("FAIL pending_if_data got %h want 44332211", if_data_o); end
    if_req_i = 1'b0;
    cyc();
    checks++; if (wmem[12'h100] !== 8'hEF) begin errors++; $display("FAIL ram_100 got %h want ef", wmem[12'h100]); end
    checks++; if (wmem[12'h101] !== 8'hBE) begin errors++; $display("FAIL ram_101 got %h want be", wmem[12'h101]); end
    checks++; if (wmem[12'h102] !== 8'hAD) begin errors++; $display("FAIL ram_102 got %h want ad", wmem[12'h102]); end
    checks++; if (wmem[12'h103] !== 8'hDE) begin errors++; $display("FAIL ram_103 got %h want de", wmem[12'h103]); end
  endtask

  task automatic test_load_half();
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_size_i = 2'b01;
    mem_addr_i = 32'h201;
    cyc();
    checks++; if (ram_addr_o !== 32'h201) begin errors++; $display("FAIL half_addr0 got %h want 201", ram_addr_o); end
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL half_wr got %b want 0", ram_wr_o); end
    cyc();
    checks++; if (ram_addr_o !== 32'h202) begin errors++; $display("FAIL half_addr1 got %h want 202", ram_addr_o); end
    cyc();
    checks++; if (ram_addr_o !== 32'h202) begin errors++; $display("FAIL half_addr_hold got %h want 202", ram_addr_o); end
    checks++; if (mem_stall_req_o !== 1'b1) begin errors++; $display("FAIL half_stall got %b want 1", mem_stall_req_o); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL half_early got %b want 0", mem_done_o); end
    cyc();
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL half_done got %b want 1", mem_done_o); end
    checks++; if (mem_rdata_o !== 32'h0000_FF80) begin errors++; $display("FAIL half_data got %h want 0000ff80", mem_rdata_o); end
    checks++; if (mem_stall_req_o !== 1'b0) begin errors++; $display("FAIL half_stall_drop got %b want 0", mem_stall_req_o); end
    mem_req_i = 1'b0;
    cyc();
    checks++; if (mem_rdata_o !== 32'h0000_FF80) begin errors++; $display("FAIL half_hold got %h want 0000ff80", mem_rdata_o); end
  endtask

  task automatic test_flush_if();
    if_req_i  = 1'b1;
    if_addr_i = 32'h30;
    repeat (3) cyc();
    checks++; if (ram_addr_o !== 32'h32) begin errors++; $display("FAIL flush_pre_addr got %h want 32", ram_addr_o); end
    flush_i  = 1'b1;
    if_req_i = 1'b0;
    cyc();
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL flush_abort_addr got %h want 0", ram_addr_o); end
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL flush_abort_done got %b want 0", if_done_o); end
    checks++; if (if_data_o !== 32'h4433_2211) begin errors++; $display("FAIL flush_abort_data got %h want 44332211", if_data_o); end
    flush_i   = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL refetch_early k=%0d got %b want 0", k, if_done_o); end
    end
    cyc();
    checks++; if (if_done_o !== 1'b1) begin errors++; $display("FAIL refetch_done got %b want 1", if_done_o); end
    checks++; if (if_data_o !== 32'hDDCC_BBAA) begin errors++; $display("FAIL refetch_data got %h want ddccbbaa", if_data_o); end
    if_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_flush_done();
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    repeat (6) cyc();
    flush_i = 1'b1;
    #1;
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL done_mask got %b want 0", if_done_o); end
    checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("FAIL done_mask_stall got %b want 1", if_stall_req_o); end
    if_req_i = 1'b0;
    flush_i  = 1'b0;
    cyc();
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL done_mask_after got %b want 0", if_done_o); end
  endtask

  task automatic test_flush_mem();
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_size_i = 2'b10;
    mem_addr_i = 32'h10;
    repeat (2) cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    checks++; if (ram_addr_o !== 32'h12) begin errors++; $display("FAIL mflush_addr got %h want 12", ram_addr_o); end
    repeat (2) cyc();
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL mflush_early got %b want 0", mem_done_o); end
    cyc();
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL mflush_done got %b want 1", mem_done_o); end
    checks++; if (mem_rdata_o !== 32'h0010_0513) begin errors++; $display("FAIL mflush_data got %h want 00100513", mem_rdata_o); end
    mem_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_write();
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_size_i  = 2'b10;
    mem_addr_i  = 32'h300;
    mem_wdata_i = 32'h1122_3344;
    cyc();
    checks++; if (ram_dout_o !== 8'h44) begin errors++; $display("FAIL rw_dout0 got %h want 44", ram_dout_o); end
    cyc();
    checks++; if (ram_addr_o !== 32'h301) begin errors++; $display("FAIL rw_addr1 got %h want 301", ram_addr_o); end
    rst       = 1'b1;
    mem_req_i = 1'b0;
    cyc();
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL rw_wr got %b want 0", ram_wr_o); end
    checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL rw_addr got %h want 0", ram_addr_o); end
    checks++; if (ram_dout_o !== 8'h0) begin errors++; $display("FAIL rw_dout got %h want 0", ram_dout_o); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL rw_done got %b want 0", mem_done_o); end
    checks++; if (if_data_o !== 32'h0) begin errors++; $display("FAIL rw_if_data got %h want 0", if_data_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rw_mem_rdata got %h want 0", mem_rdata_o); end
    rst = 1'b0;
    cyc();
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL rw_done_after got %b want 0", mem_done_o); end
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL rw_wr_after got %b want 0", ram_wr_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_size_i  = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    flush_i     = 1'b0;
    repeat (2) cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_if_fetch();
    test_priority();
    test_load_half();
    test_flush_if();
    test_flush_done();
    test_flush_mem();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller that serves the two pipeline clients, instruction fetch (IF) and the MEM stage, over the single 8-bit RAM port.
- It is the source end of the pipeline stall protocol. It raises the stall requests that the stall controller turns into the stall bus, which the pipeline latches obey.
- It also honours the EX-stage branch flush by abandoning speculative fetches.
- It sits between if/mem stages and the top-level RAM pins.

Parameters:
- ADDR_WIDTH, 32, width of client and RAM addresses. Address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- if_req_i  in  1  fetch request; held until if_done_o or flush.
- if_addr_i  in  ADDR_WIDTH  fetch address.
- if_data_o  out  32  fetched instruction, little-endian.
- if_done_o  out  1  one-cycle completion pulse for IF.
- if_stall_req_o  out  1  IF stall request.
- mem_req_i  in  1  load/store request; held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- mem_addr_i  in  ADDR_WIDTH  data address.
- mem_wdata_i  in  32  store data; byte k goes to addr+k.
- mem_rdata_o  out  32  load data; raw and zero-extended (MEM stage sign-extends).
- mem_done_o  out  1  one-cycle completion pulse for MEM.
- mem_stall_req_o  out  1  MEM stall request.
- flush_i  in  1  branch taken in EX (same signal as the ID/EX latch flush).
- ram_din_i  in  8  RAM read data. It has 1-cycle latency: it reflects the ram_addr_o of the previous cycle.
- ram_dout_o  out  8  RAM write data.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_wr_o  out  1  RAM write enable.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Registers: owner (IF/MEM), base, n (byte count 1/2/4), idx, shift buffer.
- Reset (any state, including mid-transfer):
  - State goes to IDLE.
  - All outputs are 0, and if_data_o and mem_rdata_o are cleared.
  - An interrupted store may leave a partial write in RAM; this is accepted.
- IDLE:
  - mem_req_i has priority. It latches the MEM request, then goes to WRITE if mem_we_i, else READ, with idx = 0.
  - Otherwise, if_req_i && !flush_i latches an IF request (n = 4) and goes to READ.
  - A losing IF request stays pending and is not acknowledged.
- READ, cycle with index idx (0..n):
  - ram_addr_o = base + idx while idx < n; otherwise it holds base + n - 1.
  - ram_wr_o = 0.
  - On each edge with idx >= 1, capture ram_din_i into buffer byte idx-1.
  - At idx == n, go to DONE.
  - Latency: a word read takes n+1 READ cycles, and done is seen n+2 cycles after the accepting edge (6 for a word).
- WRITE, cycle idx (0..n-1):
  - ram_wr_o = 1, ram_addr_o = base + idx, ram_dout_o = mem_wdata_i byte idx.
  - At idx == n-1, go to DONE.
  - The word latency to done is n+1 cycles.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - The owner's done output = 1.
  - The owner's data output updates at the edge entering DONE. Bytes at or above n are zero.
  - Data outputs hold their value until the next completion for the same client.
- Flush:
  - IF-owned READ with flush_i = 1: abort to IDLE at the next edge, with no done and no if_data_o update.
  - IF-owned DONE with flush_i = 1: if_done_o is suppressed (combinationally masked).
  - MEM transactions are never aborted by flush.
- Stall requests (combinational):
  - if_stall_req_o = if_req_i && !if_done_o.
  - mem_stall_req_o = mem_req_i && !mem_done_o.
- Idle RAM port: when state is not READ/WRITE, ram_wr_o = 0, ram_addr_o = 0, ram_dout_o = 0.
- Back-to-back requests: a request present in the cycle after DONE is treated as new. Requesters must drop or replace req on the edge where they see done.
- No alignment checks; consecutive bytes wrap past the maximum address.

Decomposition:
- defines.v gets:
  - the size codes `MemByte / `MemHalf / `MemWord;
  - the state encodings `MC_IDLE / `MC_READ / `MC_WRITE / `MC_DONE;
  - the `RamAddrBus / `RamDataBus widths;
  - the existing `RstEnable / `True / `False.
- No sub-module; the byte shift buffer stays inline.

Test Plan:
- IF fetch at 0x00000010, RAM bytes 0x13,0x05,0x10,0x00 → ram_addr_o steps 0x10..0x13; if_done_o pulses 6 cycles after accept; if_data_o = 0x00100513.
- mem_req and if_req in the same IDLE cycle: store word 0xDEADBEEF to 0x100 → ram_wr_o high for 4 cycles with bytes EF,BE,AD,DE at 0x100..0x103; mem_done_o pulses; the IF read then starts in the cycle after DONE.
- Load half from 0x201, RAM bytes 0x80,0xFF → mem_rdata_o = 0x0000FF80 and mem_stall_req_o drops in the done cycle.
- IF read in flight (idx = 2) with flush_i pulsed → IDLE next edge, no if_done_o, if_data_o unchanged; a new if_req at 0x40 completes normally.
- flush_i during a MEM load → the load still completes and mem_done_o pulses.
- rst asserted mid-WRITE (idx = 1) → next cycle IDLE, ram_wr_o = 0, all data outputs 0, no done pulse.
